// File: rtl/uart_rx_ctrl.sv
// Register-mapped receive FIFO controller for uart_rx: data/status/control/count registers.
// Optional idle-timeout flag and threshold interrupt when UART_RX_CTRL_TIMEOUT_EN is defined.
module uart_rx_ctrl #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned TIMEOUT_CLKS = 4800
) (
    input  logic       I_clk,
    input  logic       I_reset,
    input  logic       I_rx_data_ready,
    input  logic [7:0] I_rx_data,
    input  logic       I_rx_ready,
    input  logic [1:0] I_addr,
    input  logic       I_read_en,
    input  logic       I_write_en,
    input  logic [7:0] I_wdata,
    output logic [7:0] O_rdata,
    output logic       O_rdata_valid,
    output logic       O_irq
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          irq_en;
    logic          overrun;
    logic          timeout_flag;

    logic          empty;
    logic          full;
    logic          ctrl_wr;
    logic          flush;
    logic          clr_ovr;
    logic          pop;
    logic          push;
    logic          ovr_set;
    logic          irq_next;
    logic [7:0]    rd_mux;
    logic          unused_wdata;

    assign unused_wdata = ^{I_wdata[7:3]};

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign ctrl_wr = I_write_en && (I_addr == 2'd2);
    assign flush   = ctrl_wr && I_wdata[2];
    assign clr_ovr = ctrl_wr && I_wdata[1];
    assign pop     = I_read_en && (I_addr == 2'd0) && !empty;
    // A flush frees the whole FIFO, so a same-cycle byte is always kept.
    assign push    = I_rx_data_ready && (flush || !full || pop);
    assign ovr_set = I_rx_data_ready && full && !pop && !flush;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = push ? CW'(1) : '0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count + CW'(1);
                2'b01:   count_next = count - CW'(1);
                default: count_next = count;
            endcase
        end
    end

    // Snapshot of register state before this cycle's updates.
    always_comb begin
        rd_mux = 8'h00;
        case (I_addr)
            2'd0:    rd_mux = empty ? 8'h00 : mem[rd_ptr];
            2'd1:    rd_mux = {3'b000, timeout_flag, ~I_rx_ready, overrun, full, ~empty};
            2'd2:    rd_mux = {7'b0, irq_en};
            default: rd_mux = 8'(count);
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (push) begin
            mem[wr_ptr] <= I_rx_data;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            irq_en        <= 1'b0;
            overrun       <= 1'b0;
            O_rdata       <= 8'h00;
            O_rdata_valid <= 1'b0;
            O_irq         <= 1'b0;
        end else begin
            count         <= count_next;
            O_rdata_valid <= I_read_en;
            O_irq         <= irq_next;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (ctrl_wr) begin
                irq_en <= I_wdata[0];
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
            if (I_read_en) begin
                O_rdata <= rd_mux;
            end
        end
    end

`ifdef UART_RX_CTRL_TIMEOUT_EN
    logic [15:0] idle_cnt;

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            idle_cnt     <= 16'd0;
            timeout_flag <= 1'b0;
        end else begin
            if (flush || push || pop || empty) begin
                idle_cnt <= 16'd0;
            end else if (idle_cnt != 16'(TIMEOUT_CLKS - 1)) begin
                idle_cnt <= idle_cnt + 16'd1;
            end
            if (flush || pop || empty) begin
                timeout_flag <= 1'b0;
            end else if (idle_cnt == 16'(TIMEOUT_CLKS - 1)) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    assign irq_next = irq_en && ((count >= CW'(DEPTH / 2)) || timeout_flag || overrun);
`else
    logic [15:0] unused_timeout_clks;

    assign unused_timeout_clks = 16'(TIMEOUT_CLKS);
    assign timeout_flag        = 1'b0;
    assign irq_next            = irq_en && (!empty || overrun);
`endif

endmodule
